mc6809_eqgen: RTL and testbench

Quadrature clock and reset generator for the 6809E core. From one master clock it produces the E and Q phase pair the core consumes, plus a stretched, E-aligned CPU reset. Optional MRDY handling lengthens E-high for slow memory. It sits directly upstream of the CPU wrapper: its E, Q and nRESET_OUT outputs drive the CPU's E, Q and nRESET inputs.

---
 rtl/mc6809_clk_pkg.sv | 40 ++++
 rtl/mc6809_rst_stretch.sv | 36 +++
 rtl/mc6809_eqgen.sv | 136 +++++++++++++
 tb/tb_mc6809_eqgen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mc6809_clk_pkg.sv
// Shared definitions for the 6809E E/Q clock generator: phase encoding,
// per-phase (E,Q) decode and the default timing parameters used by the
// generator and the board top.
package mc6809_clk_pkg;

  // Quarter phases of one E cycle, in order of occurrence.
  typedef enum logic [1:0] {
    PH_P0 = 2'd0,
    PH_P1 = 2'd1,
    PH_P2 = 2'd2,
    PH_P3 = 2'd3
  } phase_e;

  // {E,Q} levels for each phase. Q leads E by one quarter.
  localparam logic [1:0] EQ_P0 = 2'b00;
  localparam logic [1:0] EQ_P1 = 2'b01;
  localparam logic [1:0] EQ_P2 = 2'b11;
  localparam logic [1:0] EQ_P3 = 2'b10;

  // Default timing: CLKs per quarter, E cycles of reset stretch,
  // maximum MRDY stretch quarters per E cycle.
  localparam int DEFAULT_DIV         = 1;
  localparam int DEFAULT_RST_CYCLES  = 8;
  localparam int DEFAULT_MAX_STRETCH = 40;

  // Map a phase to its {E,Q} pair.
  function automatic logic [1:0] eq_decode(input phase_e ph);
    logic [1:0] eq;
    eq = EQ_P0;
    case (ph)
      PH_P0:   eq = EQ_P0;
      PH_P1:   eq = EQ_P1;
      PH_P2:   eq = EQ_P2;
      PH_P3:   eq = EQ_P3;
      default: eq = EQ_P0;
    endcase
    return eq;
  endfunction

endpackage

// File: rtl/mc6809_rst_stretch.sv
// Reset stretcher: holds nRESET_OUT low until CYCLE_END (the P3->P0
// strobe) has been seen RST_CYCLES times after nRESET release. Once high,
// nRESET_OUT stays high until the next nRESET assertion.
module mc6809_rst_stretch
  import mc6809_clk_pkg::*;
#(
  parameter int RST_CYCLES = DEFAULT_RST_CYCLES
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic CYCLE_END,
  output logic nRESET_OUT
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  // Count completed E cycles; latch done on the cycle that completes RST_CYCLES.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (CYCLE_END && !r_done) begin
      if (r_cnt == CW'(RST_CYCLES - 1)) begin
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign nRESET_OUT = r_done;

endmodule

// File: rtl/mc6809_eqgen.sv
// E/Q quadrature clock and stretched reset generator for the 6809E core.
// Optional feature macro: MC6809_EQGEN_MRDY_EN enables MRDY stretching of
// the P3 (E-high, Q-low) quarter; without it MRDY is ignored and
// STRETCHING is tied low.
module mc6809_eqgen
  import mc6809_clk_pkg::*;
#(
  parameter int DIV         = DEFAULT_DIV,
  parameter int RST_CYCLES  = DEFAULT_RST_CYCLES,
  parameter int MAX_STRETCH = DEFAULT_MAX_STRETCH
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic MRDY,
  output logic E,
  output logic Q,
  output logic nRESET_OUT,
  output logic E_RISE,
  output logic E_FALL,
  output logic STRETCHING
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;

  phase_e        r_phase;
  phase_e        w_phase_next;
  logic [QW-1:0] r_qcnt;
  logic          w_quarter_end;
  logic          w_stay;
  logic          w_cycle_end;
  logic          r_e;
  logic          r_q;
  logic          r_e_rise;
  logic          r_e_fall;

  assign w_quarter_end = (r_qcnt == QW'(DIV - 1));
  // End of the E cycle: leaving P3 without inserting another stretch quarter.
  assign w_cycle_end   = w_quarter_end && (r_phase == PH_P3) && !w_stay;

`ifdef MC6809_EQGEN_MRDY_EN
  localparam int SW = $clog2(MAX_STRETCH + 1);

  logic [SW-1:0] r_scnt;
  logic          r_stretching;
  logic          w_enter_p3;

  assign w_enter_p3 = w_quarter_end && (r_phase == PH_P2);
  assign w_stay     = w_quarter_end && (r_phase == PH_P3) && !MRDY &&
                      (r_scnt < SW'(MAX_STRETCH));

  // Stretch quarters used in the current P3; restarts on each entry to P3.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_scnt <= '0;
    end else if (w_enter_p3) begin
      r_scnt <= '0;
    end else if (w_stay) begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  // STRETCHING marks a whole inserted quarter; updated at each quarter boundary.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_stretching <= 1'b0;
    end else if (w_quarter_end) begin
      r_stretching <= w_stay;
    end
  end

  assign STRETCHING = r_stretching;
`else
  // MRDY and MAX_STRETCH are kept for a uniform port/parameter list only.
  localparam int max_stretch_unused = MAX_STRETCH;
  logic w_mrdy_unused;

  assign w_mrdy_unused = MRDY;
  assign w_stay        = 1'b0;
  assign STRETCHING    = 1'b0;
`endif

  // Phase register and quarter counter.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_phase <= PH_P0;
      r_qcnt  <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_qcnt  <= w_quarter_end ? '0 : (r_qcnt + 1'b1);
    end
  end

  // Next phase: advance at quarter end, P3 may repeat while stretching.
  always_comb begin
    w_phase_next = r_phase;
    if (w_quarter_end) begin
      case (r_phase)
        PH_P0:   w_phase_next = PH_P1;
        PH_P1:   w_phase_next = PH_P2;
        PH_P2:   w_phase_next = PH_P3;
        PH_P3:   w_phase_next = w_stay ? PH_P3 : PH_P0;
        default: w_phase_next = PH_P0;
      endcase
    end
  end

  // Registered E/Q decoded from the next phase, plus edge strobes, so all
  // outputs change on the same CLK edge as the phase register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_e      <= 1'b0;
      r_q      <= 1'b0;
      r_e_rise <= 1'b0;
      r_e_fall <= 1'b0;
    end else begin
      {r_e, r_q} <= eq_decode(w_phase_next);
      r_e_rise   <= w_quarter_end && (r_phase == PH_P1);
      r_e_fall   <= w_cycle_end;
    end
  end

  assign E      = r_e;
  assign Q      = r_q;
  assign E_RISE = r_e_rise;
  assign E_FALL = r_e_fall;

  mc6809_rst_stretch #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rst_stretch (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .CYCLE_END (w_cycle_end),
    .nRESET_OUT(nRESET_OUT)
  );

endmodule

// File: tb/tb_mc6809_eqgen.sv
// Scoreboard bench for mc6809_eqgen. A quarter-level reference model pushes
// the expected outputs after every CLK edge; a negedge monitor pops and
// compares. Also measures release-to-nRESET_OUT latency when MRDY is held high.
module tb_mc6809_eqgen;

  localparam int DIV         = 3;
  localparam int RST_CYCLES  = 4;
  localparam int MAX_STRETCH = 3;
  localparam int RST_CLKS    = RST_CYCLES * 4 * DIV;
  localparam int RISE_LIMIT  = RST_CLKS * (1 + MAX_STRETCH) + 8;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  logic mrdy   = 1'b1;
  logic e, q, nro, e_rise, e_fall, stretching;

  int checks   = 0;
  int failures = 0;

  // Expected {E,Q,nRESET_OUT,E_RISE,E_FALL,STRETCHING}
  logic [5:0] q_exp[$];

  // Model state: position in the E cycle in quarters (0=P0,1=P1,2=P2,
  // 3=P3, >3 = inserted stretch quarter), CLK count inside the quarter,
  // completed E cycles since release.
  int m_pos    = 0;
  int m_tick   = 0;
  int m_cycles = 0;
  bit m_er     = 0;
  bit m_ef     = 0;

  // Stimulus flag: MRDY held high across the current reset-stretch window.
  bit clean    = 0;

  always #5 clk = ~clk;

  mc6809_eqgen #(
    .DIV        (DIV),
    .RST_CYCLES (RST_CYCLES),
    .MAX_STRETCH(MAX_STRETCH)
  ) dut (
    .CLK       (clk),
    .nRESET    (nreset),
    .MRDY      (mrdy),
    .E         (e),
    .Q         (q),
    .nRESET_OUT(nro),
    .E_RISE    (e_rise),
    .E_FALL    (e_fall),
    .STRETCHING(stretching)
  );

  function automatic bit stretch_ok(input logic mrdy_s, input int pos);
`ifdef MC6809_EQGEN_MRDY_EN
    return (mrdy_s == 1'b0) && ((pos - 3) < MAX_STRETCH);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: advance by one CLK and push the expected outputs.
  always @(posedge clk) begin
    m_er = 0;
    m_ef = 0;
    if (!nreset) begin
      m_pos    = 0;
      m_tick   = 0;
      m_cycles = 0;
    end else begin
      m_tick = m_tick + 1;
      if (m_tick == DIV) begin
        m_tick = 0;
        if (m_pos < 3) begin
          m_pos = m_pos + 1;
          m_er  = (m_pos == 2);
        end else if (stretch_ok(mrdy, m_pos)) begin
          m_pos = m_pos + 1;
        end else begin
          m_pos    = 0;
          m_cycles = m_cycles + 1;
          m_ef     = 1;
        end
      end
    end
    q_exp.push_back({(m_pos >= 2), (m_pos == 1 || m_pos == 2),
                     (m_cycles >= RST_CYCLES), m_er, m_ef, (m_pos > 3)});
  end

  // Monitor: compare DUT against the scoreboard and time the reset release.
  int  since_rel = 0;
  bit  rise_done = 0;
  always @(negedge clk) begin
    logic [5:0] act;
    logic [5:0] exp_v;
    act = {e, q, nro, e_rise, e_fall, stretching};
    if (!nreset) begin
      since_rel = 0;
      rise_done = 0;
    end else begin
      since_rel = since_rel + 1;
    end

    checks = checks + 1;
    if (q_exp.size() == 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_empty t=%0t got %b required an expected entry", $time, act);
    end else begin
      exp_v = q_exp.pop_front();
      if (!nreset) exp_v = 6'b000000;
      if (act !== exp_v) begin
        failures = failures + 1;
        $display("FAIL outputs t=%0t {E,Q,nRO,ER,EF,ST} got %b required %b", $time, act, exp_v);
      end
    end

    if (nreset && !rise_done && nro) begin
      rise_done = 1;
      if (clean) begin
        checks = checks + 1;
        if (since_rel != RST_CLKS) begin
          failures = failures + 1;
          $display("FAIL nreset_out_latency got %0d CLKs required %0d", since_rel, RST_CLKS);
        end else begin
          $display("nRESET_OUT rose %0d CLKs after release", since_rel);
        end
      end
    end
    if (nreset && !rise_done && since_rel > RISE_LIMIT) begin
      rise_done = 1;
      checks    = checks + 1;
      failures  = failures + 1;
      $display("FAIL nreset_out_timeout got no rise in %0d CLKs required rise", since_rel);
    end
  end

  task automatic run_random(input int n, input int low_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1 mrdy = ($urandom_range(0, 99) < low_pct) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic assert_reset_mid_cycle(input int delay_clks);
    repeat (delay_clks) @(posedge clk);
    #2 nreset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset(input bit hold_mrdy);
    @(negedge clk);
    clean = hold_mrdy;
    if (hold_mrdy) mrdy = 1'b1;
    #2 nreset = 1'b1;
  endtask

  initial begin
`ifdef MC6809_EQGEN_MRDY_EN
    $display("mode: MRDY stretch enabled, DIV=%0d RST_CYCLES=%0d MAX_STRETCH=%0d", DIV, RST_CYCLES, MAX_STRETCH);
`else
    $display("mode: MRDY ignored, DIV=%0d RST_CYCLES=%0d", DIV, RST_CYCLES);
`endif
    repeat (4) @(negedge clk);

    $display("txn: power-on release, MRDY high");
    release_reset(1'b1);
    repeat (RST_CLKS + 12) @(negedge clk);

    $display("txn: random MRDY, 50%% low");
    run_random(300, 50);

    $display("txn: reset mid-cycle, release with MRDY high");
    assert_reset_mid_cycle(7);
    release_reset(1'b1);
    repeat (RST_CLKS + 12) @(negedge clk);

    $display("txn: random MRDY, 90%% low");
    run_random(300, 90);

    $display("txn: reset during random traffic, release with random MRDY");
    assert_reset_mid_cycle(5);
    release_reset(1'b0);
    run_random(RISE_LIMIT + 20, 70);

    $display("txn: MRDY held low");
    mrdy = 1'b0;
    repeat (120) @(negedge clk);
    mrdy = 1'b1;
    repeat (20) @(negedge clk);

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
